// File: rtl/dag_unit.sv
// dag_unit: data address generator with I/M/L/B register file and circular buffer wrap
module dag_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        ps_dg_en,
    input  logic        ps_dg_dgsclt,
    input  logic        ps_dg_mdfy,
    input  logic [2:0]  ps_dg_iadd,
    input  logic [2:0]  ps_dg_madd,
    input  logic        ps_dg_wrt_en,
    input  logic [4:0]  ps_dg_wrt_add,
    input  logic [4:0]  ps_dg_rd_add,
    input  logic [15:0] bc_dg_dt,
    output logic [15:0] dg_bc_dt,
    output logic [15:0] dg_dm_add,
    output logic [15:0] dg_ps_add,
    output logic        dg_dm_vld,
    output logic        dg_ps_vld
);
    logic [15:0] i_r [8];
    logic [15:0] m_r [8];
    logic [15:0] l_r [8];
    logic [15:0] b_r [8];
    logic [15:0] i_cur, m_cur, l_cur, b_cur, rd_val, addr, wrapped;
    logic [16:0] sum, top, sub, add;
    // ureg read with same-cycle write bypass
    always_comb begin
        rd_val = ps_dg_rd_add[4:3] == 2'd0 ? i_r[ps_dg_rd_add[2:0]] :
                 ps_dg_rd_add[4:3] == 2'd1 ? m_r[ps_dg_rd_add[2:0]] :
                 ps_dg_rd_add[4:3] == 2'd2 ? l_r[ps_dg_rd_add[2:0]] : b_r[ps_dg_rd_add[2:0]];
        dg_bc_dt = (ps_dg_wrt_en && ps_dg_wrt_add == ps_dg_rd_add) ? bc_dg_dt : rd_val;
    end
    // address and circular wrap; M is sign-extended so a negative step stays below 2^16
    always_comb begin
        i_cur = i_r[ps_dg_iadd];
        m_cur = m_r[ps_dg_madd];
        l_cur = l_r[ps_dg_iadd];
        b_cur = b_r[ps_dg_iadd];
        sum = {1'b0, i_cur} + {m_cur[15], m_cur};
        top = {1'b0, b_cur} + {1'b0, l_cur};
        sub = sum - {1'b0, l_cur};
        add = sum + {1'b0, l_cur};
        wrapped = l_cur == 16'd0 ? sum[15:0] :
                  sum >= top ? sub[15:0] :
                  sum < {1'b0, b_cur} ? add[15:0] : sum[15:0];
        addr = ps_dg_mdfy ? i_cur : sum[15:0];
    end
    // address outputs, post-modify update, then ureg write so the write wins on collision
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 8; k++) begin
                i_r[k] <= '0;
                m_r[k] <= '0;
                l_r[k] <= '0;
                b_r[k] <= '0;
            end
            dg_dm_add <= '0;
            dg_ps_add <= '0;
            dg_dm_vld <= 1'b0;
            dg_ps_vld <= 1'b0;
        end else begin
            dg_dm_vld <= ps_dg_en & ~ps_dg_dgsclt;
            dg_ps_vld <= ps_dg_en & ps_dg_dgsclt;
            if (ps_dg_en && !ps_dg_dgsclt) dg_dm_add <= addr;
            if (ps_dg_en && ps_dg_dgsclt) dg_ps_add <= addr;
            if (ps_dg_en && ps_dg_mdfy) i_r[ps_dg_iadd] <= wrapped;
            if (ps_dg_wrt_en) begin
                case (ps_dg_wrt_add[4:3])
                    2'd0: i_r[ps_dg_wrt_add[2:0]] <= bc_dg_dt;
                    2'd1: m_r[ps_dg_wrt_add[2:0]] <= bc_dg_dt;
                    2'd2: l_r[ps_dg_wrt_add[2:0]] <= bc_dg_dt;
                    default: begin
                        b_r[ps_dg_wrt_add[2:0]] <= bc_dg_dt;
                        i_r[ps_dg_wrt_add[2:0]] <= bc_dg_dt;
                    end
                endcase
            end
        end
    end
endmodule

// File: doc/dag_unit.md
# dag_unit

Data address generator sitting directly downstream of the program sequencer. It decodes the sequencer's DAG control fields (`ps_dg_*`) into a registered 16-bit memory address. Each access either pre-modifies or post-modifies an index register, with optional circular-buffer wrap. It also owns the I/M/L/B register file, which the sequencer reads and writes as universal registers through bus connect. The generated address goes to data memory (`dg_dm_add`) or back to the sequencer's PM address path (`dg_ps_add`).

## Interface
Parameters:
- none (register file fixed at 8 each of I, M, L, B; data width 16)

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-low
- `ps_dg_en`  in  1  DAG access request this cycle
- `ps_dg_dgsclt`  in  1  destination select: 0 = DM address, 1 = PM address
- `ps_dg_mdfy`  in  1  0 = pre-modify, 1 = post-modify
- `ps_dg_iadd`  in  3  index register number I0–I7
- `ps_dg_madd`  in  3  modify register number M0–M7
- `ps_dg_wrt_en`  in  1  ureg write strobe
- `ps_dg_wrt_add`  in  5  ureg write address
- `ps_dg_rd_add`  in  5  ureg read address
- `bc_dg_dt`  in  16  ureg write data from bus connect
- `dg_bc_dt`  out  16  ureg read data to bus connect
- `dg_dm_add`  out  16  data memory address (registered)
- `dg_ps_add`  out  16  program memory address to sequencer (registered)
- `dg_dm_vld`  out  1  `dg_dm_add` updated this cycle
- `dg_ps_vld`  out  1  `dg_ps_add` updated this cycle

## Operation
- Ureg address map: bits [4:3] select the group (00 = I, 01 = M, 10 = L, 11 = B); bits [2:0] select the index.
- M values are signed two's complement. I, L and B are unsigned.
- Ureg write on posedge with `ps_dg_wrt_en` = 1: target register <= `bc_dg_dt`.
- Writing B_n also loads I_n <= `bc_dg_dt`.
- Read path is combinational: `dg_bc_dt` = register at `ps_dg_rd_add`.
  - Bypass: if `ps_dg_wrt_en` = 1 and `ps_dg_wrt_add` == `ps_dg_rd_add`, then `dg_bc_dt` = `bc_dg_dt`.
- Circular wrap function W(x), computed in 17 bits:
  - If L = 0: W(x) = x[15:0] (linear modulo-2^16).
  - Else: if x ≥ B+L then x−L; else if x < B then x+L; else x. Result is truncated to 16 bits.
  - One correction step only; |M| ≥ L is undefined.
- Access with `ps_dg_en` = 1, using I = I[iadd], M = M[madd], L = L[iadd], B = B[iadd]:
  - Pre-modify (`ps_dg_mdfy` = 0): address = I+M, no wrap. I is unchanged.
  - Post-modify (`ps_dg_mdfy` = 1): address = I; I[iadd] <= W(I+M).
- Address delivery:
  - `ps_dg_dgsclt` = 0: `dg_dm_add` <= address and `dg_dm_vld` <= 1.
  - `ps_dg_dgsclt` = 1: `dg_ps_add` <= address and `dg_ps_vld` <= 1.
  - The unselected address output holds its value; its vld bit is 0.
- With `ps_dg_en` = 0: both address outputs hold and both vld bits are 0.
- Simultaneous events on the same edge:
  - The access computation uses the pre-edge register values. There is no forwarding of a same-cycle ureg write into address generation.
  - If the post-modify update and a ureg write (I_n, or B_n) target the same I_n, the ureg write wins.

## Timing
- Reset (`rst` low, async): all I/M/L/B = 0; `dg_dm_add` = `dg_ps_add` = 0; `dg_dm_vld` = `dg_ps_vld` = 0.
- `dg_bc_dt` during reset = 0, since it reads the zeroed file.
- A reset asserted mid-operation abandons any pending update. There is no partial state.
- Access latency is 1 cycle. Request sampled at edge k gives the address and vld visible after edge k. The updated I is readable from edge k onward.
- Back-to-back accesses to the same I every cycle are legal. Each one sees the I value written by the previous access.
- Ureg write latency is 1 edge. The read bypass makes the data visible in the same cycle.
- No stalls and no backpressure: one access per cycle maximum.

## Test plan
- Reset with all inputs 0 → all outputs 0. Reading every address 0–31 returns 0.
- Linear post-modify:
  - Setup: write I0 = 0x0100, M1 = 0x0004.
  - Stimulus: en = 1, mdfy = 1, iadd = 0, madd = 1, dgsclt = 0 for 3 cycles.
  - Required: `dg_dm_add` = 0x0100, 0x0104, 0x0108 with `dg_dm_vld` high; I0 = 0x010C.
- Circular buffer:
  - Setup: write B2 = 0x0200 (I2 becomes 0x0200), L2 = 5, M3 = 2.
  - Stimulus: 4 post-modify accesses on I2/M3.
  - Required: addresses 0x0200, 0x0202, 0x0204, 0x0201.
  - Follow-up: M3 = 0xFFFD (−3) from I2 = 0x0201 → I2 = 0x0203.
- Pre-modify to PM:
  - Setup: I5 = 0x0010, M5 = 0xFFFF.
  - Stimulus: en = 1, mdfy = 0, dgsclt = 1.
  - Required: `dg_ps_add` = 0x000F, `dg_ps_vld` = 1, I5 still 0x0010, and `dg_dm_add` unchanged.
- Collision:
  - Stimulus: post-modify on I0 in the same cycle as a ureg write I0 = 0x0AAA; rd_add = wrt_add = I0.
  - Required: `dg_bc_dt` = 0x0AAA in that cycle, the address uses the old I0, and I0 = 0x0AAA afterwards.
- Async reset mid-stream: assert `rst` between edges during back-to-back accesses → outputs go to 0 immediately, with no vld pulse after release until a new request.
